// File: rtl/ahblite_s_port_if.sv
// Bus bundle for one AHB-Lite slave-side port: per-master request/control lanes,
// the one-hot grant, the broadcast response and the slave-facing address/data phase.
interface ahblite_s_port_if #(
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32,
    parameter int MST_NUM = 4
) ();
    logic [MST_NUM-1:0]             m_req_i;
    logic [MST_NUM-1:0]             m_grant_o;
    logic [MST_NUM-1:0][AHB_AW-1:0] m_haddr_i;
    logic [MST_NUM-1:0]             m_hwrite_i;
    logic [MST_NUM-1:0][1:0]        m_htrans_i;
    logic [MST_NUM-1:0][2:0]        m_hsize_i;
    logic [MST_NUM-1:0][2:0]        m_hburst_i;
    logic [MST_NUM-1:0][3:0]        m_hprot_i;
    logic [MST_NUM-1:0]             m_hmastlock_i;
    logic [MST_NUM-1:0][AHB_DW-1:0] m_hwdata_i;
    logic                           m_hready_o;
    logic                           m_hresp_o;
    logic [AHB_DW-1:0]              m_hrdata_o;

    logic                           hsel_o;
    logic [AHB_AW-1:0]              haddr_o;
    logic                           hwrite_o;
    logic [1:0]                     htrans_o;
    logic [2:0]                     hsize_o;
    logic [2:0]                     hburst_o;
    logic [3:0]                     hprot_o;
    logic                           hmastlock_o;
    logic [AHB_DW-1:0]              hwdata_o;
    logic                           hready_o;
    logic                           hreadyout_i;
    logic                           hresp_i;
    logic [AHB_DW-1:0]              hrdata_i;

    // View of the arbitrating port itself
    modport slave (
        input  m_req_i, m_haddr_i, m_hwrite_i, m_htrans_i, m_hsize_i, m_hburst_i,
               m_hprot_i, m_hmastlock_i, m_hwdata_i, hreadyout_i, hresp_i, hrdata_i,
        output m_grant_o, m_hready_o, m_hresp_o, m_hrdata_o, hsel_o, haddr_o, hwrite_o,
               htrans_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o, hready_o
    );

    // View of the surrounding master ports and slave device
    modport master (
        output m_req_i, m_haddr_i, m_hwrite_i, m_htrans_i, m_hsize_i, m_hburst_i,
               m_hprot_i, m_hmastlock_i, m_hwdata_i, hreadyout_i, hresp_i, hrdata_i,
        input  m_grant_o, m_hready_o, m_hresp_o, m_hrdata_o, hsel_o, haddr_o, hwrite_o,
               htrans_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o, hready_o
    );
endinterface

// File: rtl/ahblite_s_port.sv
// AHB-Lite slave-side port: round-robin arbitration over MST_NUM master ports, owner mux to
// the slave, broadcast response. Define AHBLITE_S_PORT_LOCK_EN to let hmastlock hold the grant.
module ahblite_s_port #(
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32,
    parameter int MST_NUM = 4
) (
    input  logic             clk,
    input  logic             rst,
    ahblite_s_port_if.slave  bus
);
    localparam int PW = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10
    } state_t;

    typedef struct packed {
        logic [AHB_AW-1:0] haddr;
        logic              hwrite;
        logic [1:0]        htrans;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
        logic [AHB_DW-1:0] hwdata;
    } mreq_t;

    localparam int RW = $bits(mreq_t);

    state_t                     state_q;
    logic [MST_NUM-1:0]         grant_q;
    logic [PW-1:0]              rr_ptr;

    mreq_t [MST_NUM-1:0]        lane_in;
    logic  [MST_NUM-1:0][RW-1:0] lane_out;
    logic  [RW-1:0]             own_vec;
    mreq_t                      own;
    logic  [PW-1:0]             own_idx;
    logic  [PW-1:0]             rr_nxt;
    logic  [PW-1:0]             win_idx;
    logic                       win_found;
    logic  [PW:0]               cand;
    logic                       granted;
    logic                       fwd;

    always_comb begin
        lane_in = '0;
        for (int i = 0; i < MST_NUM; i++) begin
            lane_in[i].haddr     = bus.m_haddr_i[i];
            lane_in[i].hwrite    = bus.m_hwrite_i[i];
            lane_in[i].htrans    = bus.m_htrans_i[i];
            lane_in[i].hsize     = bus.m_hsize_i[i];
            lane_in[i].hburst    = bus.m_hburst_i[i];
            lane_in[i].hprot     = bus.m_hprot_i[i];
            lane_in[i].hmastlock = bus.m_hmastlock_i[i];
            lane_in[i].hwdata    = bus.m_hwdata_i[i];
        end
    end

    // One-hot grant makes the owner mux a plain AND-OR across lanes
    for (genvar g = 0; g < MST_NUM; g++) begin : g_lane
        assign lane_out[g] = lane_in[g] & {RW{grant_q[g]}};
    end

    always_comb begin
        own_vec = '0;
        own_idx = '0;
        for (int i = 0; i < MST_NUM; i++) begin
            own_vec = own_vec | lane_out[i];
            if (grant_q[i]) own_idx = PW'(i);
        end
    end

    assign own    = mreq_t'(own_vec);
    assign rr_nxt = (own_idx == PW'(MST_NUM - 1)) ? '0 : own_idx + 1'b1;

    // First requester at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < MST_NUM; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(MST_NUM)) cand = cand - (PW+1)'(MST_NUM);
            if (!win_found && bus.m_req_i[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

`ifdef AHBLITE_S_PORT_LOCK_EN
    // A locked owner keeps the bus for NONSEQ and IDLE as well as SEQ/BUSY
    assign fwd = own.htrans[0] | own.hmastlock;
`else
    assign fwd = own.htrans[0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q <= MST_NUM'(1) << win_idx;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: state_q <= S_DATA;
                S_DATA: begin
                    if (bus.hreadyout_i && !fwd) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        rr_ptr  <= rr_nxt;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign granted = (state_q == S_ADDR) || (state_q == S_DATA);

    always_comb begin
        bus.htrans_o = 2'b00;
        case (state_q)
            S_ADDR:  bus.htrans_o = own.htrans;
            S_DATA:  bus.htrans_o = fwd ? own.htrans : 2'b00;
            default: bus.htrans_o = 2'b00;
        endcase
    end

    assign bus.m_grant_o   = grant_q;
    assign bus.hsel_o      = granted;
    assign bus.haddr_o     = granted ? own.haddr : '0;
    assign bus.hwrite_o    = granted & own.hwrite;
    assign bus.hsize_o     = granted ? own.hsize : '0;
    assign bus.hburst_o    = granted ? own.hburst : '0;
    assign bus.hprot_o     = granted ? own.hprot : '0;
    assign bus.hmastlock_o = granted & own.hmastlock;
    assign bus.hwdata_o    = (state_q == S_DATA) ? own.hwdata : '0;
    assign bus.hready_o    = (state_q == S_DATA) ? bus.hreadyout_i : 1'b1;

    assign bus.m_hready_o  = bus.hreadyout_i;
    assign bus.m_hresp_o   = bus.hresp_i;
    assign bus.m_hrdata_o  = bus.hrdata_i;
endmodule

// File: tb/tb_ahblite_s_port.sv
// Directed bench for ahblite_s_port: reset, single transfer, round robin, wait states,
// error response, locked transfers and asynchronous reset during a burst.
module tb_ahblite_s_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MN = 4;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SGL  = 3'b000;
    localparam logic [2:0] B_INC4 = 3'b011;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    ahblite_s_port_if #(.AHB_AW(AW), .AHB_DW(DW), .MST_NUM(MN)) bus ();

    ahblite_s_port #(.AHB_AW(AW), .AHB_DW(DW), .MST_NUM(MN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] i, input logic [31:0] a, input logic [1:0] t,
                       input logic [2:0] b, input logic lk, input logic [31:0] wd);
        bus.m_haddr_i[i]     = a;
        bus.m_htrans_i[i]    = t;
        bus.m_hburst_i[i]    = b;
        bus.m_hmastlock_i[i] = lk;
        bus.m_hwdata_i[i]    = wd;
        bus.m_hwrite_i[i]    = 1'b1;
        bus.m_hsize_i[i]     = 3'b010;
        bus.m_hprot_i[i]     = 4'b0011;
    endtask

    task automatic clr_all();
        bus.m_req_i       = '0;
        bus.m_haddr_i     = '0;
        bus.m_hwrite_i    = '0;
        bus.m_htrans_i    = '0;
        bus.m_hsize_i     = '0;
        bus.m_hburst_i    = '0;
        bus.m_hprot_i     = '0;
        bus.m_hmastlock_i = '0;
        bus.m_hwdata_i    = '0;
        bus.hreadyout_i   = 1'b1;
        bus.hresp_i       = 1'b0;
        bus.hrdata_i      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        clr_all();
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        n_chk = 0;
        n_err = 0;
        clr_all();
        #2;
        check("rst_grant",  32'(bus.m_grant_o), 0);
        check("rst_htrans", 32'(bus.htrans_o), 0);
        check("rst_hready", 32'(bus.hready_o), 1);
        check("rst_hsel",   32'(bus.hsel_o), 0);
        check("rst_haddr",  bus.haddr_o, 0);
        check("rst_hwdata", bus.hwdata_o, 0);
        #10 rst = 1'b1;

        // single request from master 1
        bus.hrdata_i = 32'h1234_5678;
        drv(2'd1, 32'h0001_0040, T_NSEQ, B_SGL, 1'b0, 32'h0);
        bus.m_req_i = 4'b0010;
        #1;
        check("idle_hrdata", bus.m_hrdata_o, 32'h1234_5678);
        check("idle_nogrant", 32'(bus.m_grant_o), 0);
        step();
        bus.m_req_i = '0;
        #1;
        check("sgl_grant",  32'(bus.m_grant_o), 32'h2);
        check("sgl_hsel",   32'(bus.hsel_o), 1);
        check("sgl_haddr",  bus.haddr_o, 32'h0001_0040);
        check("sgl_htrans", 32'(bus.htrans_o), 32'h2);
        check("sgl_hsize",  32'(bus.hsize_o), 32'h2);
        check("sgl_hprot",  32'(bus.hprot_o), 32'h3);
        check("sgl_hready", 32'(bus.hready_o), 1);
        step();
        drv(2'd1, 32'h0001_0044, T_IDLE, B_SGL, 1'b0, 32'hA5A5_0001);
        #1;
        check("sgl_hwdata",   bus.hwdata_o, 32'hA5A5_0001);
        check("sgl_d_htrans", 32'(bus.htrans_o), 0);
        check("sgl_d_grant",  32'(bus.m_grant_o), 32'h2);
        step();
        #1;
        check("sgl_rel_grant", 32'(bus.m_grant_o), 0);
        check("sgl_rel_hsel",  32'(bus.hsel_o), 0);

        // round robin with everyone requesting
        do_reset();
        for (int k = 0; k < MN; k++)
            drv(2'(k), 32'(32'h1000 * (k + 1)), T_NSEQ, B_SGL, 1'b0, 32'(32'hD0 + k));
        bus.m_req_i = 4'hF;
        for (int t = 0; t < 5; t++) begin
            step();
            #1;
            check("rr_grant", 32'(bus.m_grant_o), 32'(1 << (t % 4)));
            check("rr_haddr", bus.haddr_o, 32'(32'h1000 * ((t % 4) + 1)));
            step();
            #1;
            check("rr_d_htrans", 32'(bus.htrans_o), 0);
            check("rr_hwdata", bus.hwdata_o, 32'(32'hD0 + (t % 4)));
            step();
            #1;
            check("rr_gap", 32'(bus.m_grant_o), 0);
        end
        bus.m_req_i = '0;

        // INCR4 from master 2 with three wait states on beat 2
        clr_all();
        drv(2'd2, 32'h200, T_NSEQ, B_INC4, 1'b0, 32'h0);
        bus.m_req_i = 4'b0100;
        step();
        bus.m_req_i = '0;
        #1;
        check("ws_grant",  32'(bus.m_grant_o), 32'h4);
        check("ws_haddr0", bus.haddr_o, 32'h200);
        check("ws_hburst", 32'(bus.hburst_o), 32'h3);
        step();
        drv(2'd2, 32'h204, T_SEQ, B_INC4, 1'b0, 32'hB0);
        #1;
        check("ws_b1_wdata",  bus.hwdata_o, 32'hB0);
        check("ws_b1_htrans", 32'(bus.htrans_o), 32'h3);
        check("ws_b1_haddr",  bus.haddr_o, 32'h204);
        step();
        drv(2'd2, 32'h208, T_SEQ, B_INC4, 1'b0, 32'hB1);
        bus.hreadyout_i = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #1;
            check("ws_hold_ready",  32'(bus.hready_o), 0);
            check("ws_hold_grant",  32'(bus.m_grant_o), 32'h4);
            check("ws_hold_wdata",  bus.hwdata_o, 32'hB1);
            check("ws_hold_haddr",  bus.haddr_o, 32'h208);
            check("ws_hold_htrans", 32'(bus.htrans_o), 32'h3);
            step();
        end
        bus.hreadyout_i = 1'b1;
        #1;
        check("ws_b2_ready", 32'(bus.hready_o), 1);
        check("ws_b2_wdata", bus.hwdata_o, 32'hB1);
        step();
        drv(2'd2, 32'h20C, T_SEQ, B_INC4, 1'b0, 32'hB2);
        #1;
        check("ws_b3_wdata", bus.hwdata_o, 32'hB2);
        check("ws_b3_haddr", bus.haddr_o, 32'h20C);
        step();
        drv(2'd2, 32'h0, T_IDLE, B_SGL, 1'b0, 32'hB3);
        #1;
        check("ws_b4_wdata",  bus.hwdata_o, 32'hB3);
        check("ws_b4_htrans", 32'(bus.htrans_o), 0);
        check("ws_b4_grant",  32'(bus.m_grant_o), 32'h4);
        step();
        #1;
        check("ws_rel_grant", 32'(bus.m_grant_o), 0);

        // two-cycle ERROR response from master 3
        drv(2'd3, 32'h300, T_NSEQ, B_SGL, 1'b0, 32'h0);
        bus.m_req_i = 4'b1000;
        step();
        bus.m_req_i = '0;
        #1;
        check("err_grant", 32'(bus.m_grant_o), 32'h8);
        step();
        drv(2'd3, 32'h0, T_IDLE, B_SGL, 1'b0, 32'hE0);
        bus.hresp_i     = 1'b1;
        bus.hreadyout_i = 1'b0;
        #1;
        check("err1_hresp",   32'(bus.m_hresp_o), 1);
        check("err1_mhready", 32'(bus.m_hready_o), 0);
        check("err1_hready",  32'(bus.hready_o), 0);
        step();
        #1;
        check("err1_grant", 32'(bus.m_grant_o), 32'h8);
        bus.hreadyout_i = 1'b1;
        #1;
        check("err2_hresp",   32'(bus.m_hresp_o), 1);
        check("err2_mhready", 32'(bus.m_hready_o), 1);
        check("err2_grant",   32'(bus.m_grant_o), 32'h8);
        step();
        bus.hresp_i = 1'b0;
        #1;
        check("err_rel_grant", 32'(bus.m_grant_o), 0);

        // master 1 locked pair against master 3
        drv(2'd1, 32'h100, T_NSEQ, B_SGL, 1'b1, 32'h0);
        drv(2'd3, 32'h300, T_NSEQ, B_SGL, 1'b0, 32'h0);
        bus.m_req_i = 4'b1010;
        step();
        #1;
        check("lk_grant1", 32'(bus.m_grant_o), 32'h2);
        check("lk_haddr1", bus.haddr_o, 32'h100);
        check("lk_lock1",  32'(bus.hmastlock_o), 1);
        step();
        drv(2'd1, 32'h104, T_NSEQ, B_SGL, 1'b1, 32'hC0);
        #1;
`ifdef AHBLITE_S_PORT_LOCK_EN
        check("lk_fwd_htrans", 32'(bus.htrans_o), 32'h2);
        check("lk_fwd_haddr",  bus.haddr_o, 32'h104);
        step();
        drv(2'd1, 32'h0, T_IDLE, B_SGL, 1'b0, 32'hC1);
        bus.m_req_i = 4'b1000;
        #1;
        check("lk_hold_grant", 32'(bus.m_grant_o), 32'h2);
        check("lk_end_htrans", 32'(bus.htrans_o), 0);
        step();
        #1;
        check("lk_gap", 32'(bus.m_grant_o), 0);
        step();
        #1;
        check("lk_m3_grant", 32'(bus.m_grant_o), 32'h8);
`else
        check("nl_htrans", 32'(bus.htrans_o), 0);
        step();
        #1;
        check("nl_gap", 32'(bus.m_grant_o), 0);
        step();
        #1;
        check("nl_m3_between", 32'(bus.m_grant_o), 32'h8);
        step();
        drv(2'd3, 32'h0, T_IDLE, B_SGL, 1'b0, 32'h0);
        bus.m_req_i = 4'b0010;
        step();
        step();
        #1;
        check("nl_m1_again", 32'(bus.m_grant_o), 32'h2);
        check("nl_m1_haddr", bus.haddr_o, 32'h104);
`endif
        bus.m_req_i = '0;
        step();
        clr_all();
        step();
        #1;
        check("lk_done_grant", 32'(bus.m_grant_o), 0);

        // asynchronous reset in the middle of a burst
        drv(2'd0, 32'h400, T_NSEQ, B_INC4, 1'b0, 32'h0);
        bus.m_req_i = 4'b0001;
        step();
        bus.m_req_i = '0;
        step();
        drv(2'd0, 32'h404, T_SEQ, B_INC4, 1'b0, 32'hF0);
        #1;
        check("ar_pre_htrans", 32'(bus.htrans_o), 32'h3);
        bus.hreadyout_i = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("ar_grant",  32'(bus.m_grant_o), 0);
        check("ar_htrans", 32'(bus.htrans_o), 0);
        check("ar_hready", 32'(bus.hready_o), 1);
        check("ar_hsel",   32'(bus.hsel_o), 0);
        #1;
        rst = 1'b1;
        clr_all();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
